// File: rtl/mem_sim_pkg.sv
// Shared types and constants for the memory-timing simulation blocks.
package mem_sim_pkg;

    // Wait-timer FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } timer_state_t;

    // CPU clocks per DIMM clock on the reference platform.
    localparam int CPU_PER_DIMM = 2;

    // CPU clock period in femtoseconds (3.2 GHz).
    localparam int CPU_PERIOD_FS = 312500;

endpackage

// File: rtl/dimm_phase_gen.sv
// DIMM clock phase generator: divides enabled CPU clocks by DIV, emits a
// registered one-clock tick per completed DIMM cycle and counts those ticks.
module dimm_phase_gen #(
    parameter int DIV   = 2,
    parameter int CNT_W = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             run,
    output logic             tick_edge,
    output logic             dimm_tick,
    output logic [CNT_W-1:0] dimm_cycles
);

    localparam int PH_W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [PH_W-1:0] LAST = PH_W'(DIV - 1);

    logic [PH_W-1:0] phase;

    // Combinational "this enabled edge completes a DIMM cycle"; the timer FSM
    // uses it so its decrement lines up with the registered dimm_tick.
    assign tick_edge = run && (phase == LAST);

    // Advance phase on enabled edges; tick and count on the wrap edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            phase       <= '0;
            dimm_tick   <= 1'b0;
            dimm_cycles <= '0;
        end else if (run) begin
            dimm_tick <= tick_edge;
            if (tick_edge) begin
                phase       <= '0;
                dimm_cycles <= dimm_cycles + CNT_W'(1);
            end else begin
                phase <= phase + PH_W'(1);
            end
        end else begin
            dimm_tick <= 1'b0;
        end
    end

endmodule

// File: rtl/dimm_cycle_timer.sv
// DIMM cycle timer: counts enabled CPU clocks and DIMM cycles, and times
// waits of wait_len DIMM cycles with an IDLE/COUNT/DONE FSM.
// enable is active-low: 0 runs the block, 1 freezes all state.
module dimm_cycle_timer
    import mem_sim_pkg::*;
#(
    parameter int DIV    = CPU_PER_DIMM,
    parameter int CNT_W  = 64,
    parameter int WAIT_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              start,
    input  logic [WAIT_W-1:0] wait_len,
    output logic              dimm_tick,
    output logic [CNT_W-1:0]  cpu_cycles,
    output logic [CNT_W-1:0]  dimm_cycles,
    output logic              busy,
    output logic              done,
    output timer_state_t      state_dbg
);

    generate
        if (DIV < 2) begin : g_bad_div
            $fatal(1, "dimm_cycle_timer: DIV must be at least 2");
        end
    endgenerate

    logic              run;
    logic              tick_edge;
    timer_state_t      state;
    timer_state_t      next_state;
    logic [WAIT_W-1:0] remaining;
    logic [WAIT_W-1:0] remaining_next;
    logic              busy_next;
    logic              done_next;

    assign run       = ~enable;
    assign state_dbg = state;

    dimm_phase_gen #(
        .DIV   (DIV),
        .CNT_W (CNT_W)
    ) u_phase (
        .clock       (clock),
        .reset       (reset),
        .run         (run),
        .tick_edge   (tick_edge),
        .dimm_tick   (dimm_tick),
        .dimm_cycles (dimm_cycles)
    );

    // State, remaining count, registered status outputs and CPU cycle counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            remaining  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            cpu_cycles <= '0;
        end else begin
            state     <= next_state;
            remaining <= remaining_next;
            busy      <= busy_next;
            done      <= done_next;
            if (run) begin
                cpu_cycles <= cpu_cycles + CNT_W'(1);
            end
        end
    end

    // Next state and remaining count. A tick landing on the load edge counts
    // toward the wait, so the load already takes it off; a wait that this
    // empties goes straight to DONE.
    always_comb begin
        next_state     = state;
        remaining_next = remaining;
        case (state)
            IDLE: begin
                if (start) begin
                    if (wait_len == '0) begin
                        next_state = DONE;
                    end else begin
                        remaining_next = wait_len - WAIT_W'(tick_edge);
                        next_state     = (remaining_next == '0) ? DONE : COUNT;
                    end
                end
            end
            COUNT: begin
                if (tick_edge) begin
                    remaining_next = remaining - WAIT_W'(1);
                    if (remaining == WAIT_W'(1)) begin
                        next_state = DONE;
                    end
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
        if (!run) begin
            next_state     = state;
            remaining_next = remaining;
        end
    end

    // Status outputs follow the state being entered; done drops on frozen edges.
    always_comb begin
        busy_next = (next_state == COUNT);
        done_next = run && (next_state == DONE);
    end

endmodule

// File: tb/tb_dimm_cycle_timer.sv
// Directed bench for dimm_cycle_timer with a small reference model and a
// queue of expected done-pulse edge numbers.
module tb_dimm_cycle_timer;
    import mem_sim_pkg::*;

    localparam int DIV_TB = 2;

    logic        clock;
    logic        reset;
    logic        enable;
    logic        start;
    logic [7:0]  wait_len;
    logic        dimm_tick;
    logic [63:0] cpu_cycles;
    logic [63:0] dimm_cycles;
    logic        busy;
    logic        done;
    timer_state_t state_dbg;

    logic        s_dimm_tick;
    logic [3:0]  s_cpu_cycles;
    logic [3:0]  s_dimm_cycles;
    logic        s_busy;
    logic        s_done;
    timer_state_t s_state_dbg;

    int          checks;
    int          failures;
    int          edge_n;
    logic [63:0] m_cpu;
    logic [63:0] m_dimm;
    int          m_phase;
    logic [31:0] exp_q[$];
    logic [63:0] cpu_at_freeze;
    int          p0;
    int          base;

    dimm_cycle_timer #(.DIV(DIV_TB), .CNT_W(64), .WAIT_W(8)) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .start       (start),
        .wait_len    (wait_len),
        .dimm_tick   (dimm_tick),
        .cpu_cycles  (cpu_cycles),
        .dimm_cycles (dimm_cycles),
        .busy        (busy),
        .done        (done),
        .state_dbg   (state_dbg)
    );

    dimm_cycle_timer #(.DIV(DIV_TB), .CNT_W(4), .WAIT_W(8)) dut_small (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .start       (start),
        .wait_len    (wait_len),
        .dimm_tick   (s_dimm_tick),
        .cpu_cycles  (s_cpu_cycles),
        .dimm_cycles (s_dimm_cycles),
        .busy        (s_busy),
        .done        (s_done),
        .state_dbg   (s_state_dbg)
    );

    // Clock
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Edge number after which done should be seen for a start sampled at
    // edge k with phase p before that edge and wait length n.
    function automatic int done_edge(input int k, input int p, input int n);
        int t1;
        if (n == 0) return k;
        t1 = (p == DIV_TB - 1) ? k : k + (DIV_TB - 1 - p);
        return t1 + DIV_TB * (n - 1);
    endfunction

    task automatic model_reset();
        m_cpu   = '0;
        m_dimm  = '0;
        m_phase = 0;
    endtask

    // One clock: advance the model using the inputs held over the edge,
    // then compare counters, tick and any done pulse.
    task automatic step();
        logic en_now;
        logic exp_tick;
        logic [31:0] exp_e;
        logic [3:0] lo_cpu;
        logic [3:0] lo_dimm;
        en_now = ~enable;
        @(posedge clock);
        #1;
        edge_n++;
        exp_tick = en_now && (m_phase == DIV_TB - 1);
        if (en_now) begin
            m_cpu = m_cpu + 64'd1;
            if (m_phase == DIV_TB - 1) begin
                m_phase = 0;
                m_dimm  = m_dimm + 64'd1;
            end else begin
                m_phase = m_phase + 1;
            end
        end
        lo_cpu  = m_cpu[3:0];
        lo_dimm = m_dimm[3:0];
        chk("dimm_tick", dimm_tick, exp_tick);
        chk("cpu_cycles", cpu_cycles, m_cpu);
        chk("dimm_cycles", dimm_cycles, m_dimm);
        chk("small_cpu_cycles", s_cpu_cycles, lo_cpu);
        chk("small_dimm_cycles", s_dimm_cycles, lo_dimm);
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("spurious_done", done, 1'b0);
            end else begin
                exp_e = exp_q.pop_front();
                chk("done_edge", edge_n, exp_e);
                chk("busy_at_done", busy, 1'b0);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        edge_n   = 0;
        reset    = 1'b1;
        enable   = 1'b1;
        start    = 1'b0;
        wait_len = 8'd0;
        model_reset();

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        chk("rst_dimm_tick", dimm_tick, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_cpu", cpu_cycles, 64'd0);
        chk("rst_dimm", dimm_cycles, 64'd0);
        chk("rst_state", state_dbg, IDLE);
        reset = 1'b0;

        // Free run, 10 enabled edges
        enable = 1'b0;
        repeat (10) step();
        chk("run10_cpu", cpu_cycles, 64'd10);
        chk("run10_dimm", dimm_cycles, 64'd5);

        // Wait of 3 from phase 0, with an ignored start while busy
        wait_len = 8'd3;
        start    = 1'b1;
        exp_q.push_back(done_edge(edge_n + 1, m_phase, 3));
        step();
        start = 1'b0;
        chk("w3_busy_rise", busy, 1'b1);
        chk("w3_state", state_dbg, COUNT);
        wait_len = 8'd0;
        start    = 1'b1;
        step();
        start = 1'b0;
        repeat (8) step();
        chk("w3_busy_end", busy, 1'b0);
        chk("w3_state_end", state_dbg, IDLE);

        // Zero-length wait, start held through the DONE cycle
        wait_len = 8'd0;
        start    = 1'b1;
        exp_q.push_back(done_edge(edge_n + 1, m_phase, 0));
        step();
        chk("w0_done", done, 1'b1);
        chk("w0_busy", busy, 1'b0);
        step();
        start = 1'b0;
        chk("w0_done_drop", done, 1'b0);
        chk("w0_state_idle", state_dbg, IDLE);

        // Freeze for 5 clocks with remaining=2
        wait_len = 8'd3;
        start    = 1'b1;
        p0       = m_phase;
        base     = done_edge(edge_n + 1, m_phase, 3);
        exp_q.push_back(base + 5);
        step();
        start = 1'b0;
        if (p0 != DIV_TB - 1) step();
        cpu_at_freeze = m_cpu;
        enable = 1'b1;
        repeat (5) step();
        chk("frz_cpu", cpu_cycles, cpu_at_freeze);
        chk("frz_busy", busy, 1'b1);
        chk("frz_state", state_dbg, COUNT);
        enable = 1'b0;
        repeat (8) step();

        // Asynchronous reset mid-COUNT
        wait_len = 8'd5;
        start    = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        chk("pre_rst_busy", busy, 1'b1);
        reset = 1'b1;
        #2;
        chk("arst_dimm_tick", dimm_tick, 1'b0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_done", done, 1'b0);
        chk("arst_cpu", cpu_cycles, 64'd0);
        chk("arst_dimm", dimm_cycles, 64'd0);
        chk("arst_state", state_dbg, IDLE);
        chk("arst_small_cpu", s_cpu_cycles, 4'd0);
        reset = 1'b0;
        model_reset();
        #1;

        // 17 enabled edges: no done appears, 4-bit counters wrap
        repeat (15) step();
        chk("wrap_cpu_15", s_cpu_cycles, 4'd15);
        step();
        chk("wrap_cpu_0", s_cpu_cycles, 4'd0);
        step();
        chk("wrap_cpu_1", s_cpu_cycles, 4'd1);
        chk("wrap_dimm", s_dimm_cycles, 4'd8);
        chk("wide_cpu_17", cpu_cycles, 64'd17);
        chk("no_done_after_rst", busy, 1'b0);

        chk("pending_done", exp_q.size(), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
